io_port_arbiter: RTL and testbench
==================================

# io_port_arbiter

Sequencing controller between the RISC processor core and its four 8-bit external-world ports. It arbitrates request/acknowledge traffic from the four input ports round-robin and queues each captured byte, tagged with its port, in a small FIFO that the core pops. It also registers core writes onto the four output ports with a one-cycle strobe. It sits beside the core inside `RISCprocessor`, replacing direct wiring of `InpExtWorld*` / `OutExtWorld*`.

## Interface
- `FIFO_DEPTH`, 4: input queue depth. Must be a power of two, ≥2.
- `clk`  in  1  sole clock. All state changes on the rising edge.
- `Reset`  in  1  synchronous, active-low reset. `Reset`=0 at a rising edge resets the block.
- `InpExtWorld1`..`InpExtWorld4`  in  8 each  input port data. Must be stable while the matching request is high.
- `InpReq`  in  4  bit i = port i+1 has a byte pending.
- `InpAck`  out  4  bit i is a one-cycle pulse meaning port i+1's byte was captured.
- `RdEn`  in  1  core pops the FIFO head.
- `RdValid`  out  1  FIFO non-empty.
- `RdData`  out  8  head byte (show-ahead).
- `RdPort`  out  2  head source port (0..3 = port 1..4).
- `FifoCount`  out  log2(FIFO_DEPTH)+1  entries held.
- `WrEn`  in  1  core output write.
- `WrPort`  in  2  target output port (0..3).
- `WrData`  in  8  byte to drive.
- `OutExtWorld1`..`OutExtWorld4`  out  8 each  registered output ports.
- `OutStb`  out  4  bit i is a one-cycle pulse meaning `OutExtWorld{i+1}` was updated.

## Operation
- Arbiter FSM states:
  - IDLE: if any `InpReq` bit is set and `FifoCount` < `FIFO_DEPTH`:
    - grant the first requesting port at or after `last_grant+1` (mod 4);
    - push {port, `InpExtWorldN`} into the FIFO;
    - latch the grant, set `last_grant` to the grant, and go to ACK.
    - Otherwise stay in IDLE.
  - ACK: drive `InpAck[grant]`=1 for exactly this cycle, then go to RELEASE.
  - RELEASE: wait until `InpReq[grant]`=0, then go to IDLE. Other ports' requests are held off, not lost.
- Requester contract: hold request and data until the ack is seen, then drop the request. A port that never drops its request stalls the arbiter in RELEASE; this is intended.
- Round-robin: after reset `last_grant`=3, so port 1 has highest priority.
- FIFO:
  - A push happens only from IDLE with space available.
  - A pop happens when `RdEn`=1 and `RdValid`=1.
  - Pop and push in the same cycle: both take effect and the count is unchanged.
  - When full, no grant is issued, even if a pop occurs that cycle. The grant happens on the next IDLE evaluation.
  - Pop when empty is ignored, with no state change.
  - Read/write pointers wrap modulo `FIFO_DEPTH`.
  - `RdData` and `RdPort` are 0 when empty.
- Output path: when `WrEn`=1, `OutExtWorld{WrPort+1}` <= `WrData` and `OutStb[WrPort]` <= 1 for the next cycle only. Other ports hold their values. Back-to-back writes are allowed every cycle. The output path is independent of the arbiter.
- Reset (including mid-transaction):
  - FSM to IDLE, `last_grant`=3, FIFO emptied.
  - All outputs 0: `InpAck`, `RdValid`, `RdData`, `RdPort`, `FifoCount`, `OutExtWorld1`..`4`, `OutStb`.
  - A transaction interrupted by reset is abandoned. The requester sees no ack and re-presents its byte.

## Timing
- Request sampled high at edge k (in IDLE, space available): entry written at edge k, so `RdValid`/`FifoCount` reflect it after edge k. `InpAck` is high from edge k+1 to edge k+2.
- Minimum grant spacing is 3 cycles (IDLE, ACK, RELEASE with the request already dropped).
- Pop at edge k: the next head is visible after edge k.
- Write at edge k: the port value and `OutStb` are updated after edge k; `OutStb` clears at edge k+1 unless another write targets the same port.
- Reset takes effect at the first rising edge with `Reset`=0. The block operates from the first edge with `Reset`=1.

## Test plan
- Reset check: `Reset`=0 for 2 cycles with `InpReq`=4'b1111 and `WrEn`=1 -> all outputs 0 and no ack. After release, port 1 is granted first.
- Single transfer: port 3 requests with data 8'hA5, drops the request after its ack -> `InpAck`=4'b0100 for exactly one cycle; `RdValid`=1, `RdData`=8'hA5, `RdPort`=2. `RdEn` pulse -> `RdValid`=0.
- Round-robin: all four requesting continuously, each dropping after its ack and reasserting with new data, no pops -> capture order 1,2,3,4. FIFO full (count 4), then no further ack until a pop. After the pop, port 1 is granted.
- Full plus simultaneous events: FIFO full with a pop and a request in the same cycle -> count becomes 3 that cycle, grant on the next cycle, count back to 4. Pop on empty -> no change.
- Wrap-around: push and pop 10 bytes through the depth-4 FIFO -> data and port tags return in order with no loss or duplication.
- Output writes: `WrEn` on consecutive cycles to port 2 (8'h11) then port 4 (8'h22) -> `OutExtWorld2`=8'h11 and `OutStb`=4'b0010, then `OutExtWorld4`=8'h22 and `OutStb`=4'b1000. `OutExtWorld2` holds 8'h11. Reset during RELEASE -> FSM idle, FIFO empty, outputs 0.

Source files
------------

// File: rtl/io_port_arbiter_if.sv
// Bundle of the core-side and external-world port signals of io_port_arbiter.
// The master modport is the core/world side; slave is the arbiter itself.
interface io_port_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    InpExtWorld1;
  logic [7:0]    InpExtWorld2;
  logic [7:0]    InpExtWorld3;
  logic [7:0]    InpExtWorld4;
  logic [3:0]    InpReq;
  logic [3:0]    InpAck;
  logic          RdEn;
  logic          RdValid;
  logic [7:0]    RdData;
  logic [1:0]    RdPort;
  logic [CW-1:0] FifoCount;
  logic          WrEn;
  logic [1:0]    WrPort;
  logic [7:0]    WrData;
  logic [7:0]    OutExtWorld1;
  logic [7:0]    OutExtWorld2;
  logic [7:0]    OutExtWorld3;
  logic [7:0]    OutExtWorld4;
  logic [3:0]    OutStb;

  modport master (
    output InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4, InpReq,
    output RdEn, WrEn, WrPort, WrData,
    input  InpAck, RdValid, RdData, RdPort, FifoCount,
    input  OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4, OutStb
  );

  modport slave (
    input  InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4, InpReq,
    input  RdEn, WrEn, WrPort, WrData,
    output InpAck, RdValid, RdData, RdPort, FifoCount,
    output OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4, OutStb
  );
endinterface

// File: rtl/io_port_arbiter.sv
// Round-robin request/ack arbiter for four 8-bit input ports feeding a port-tagged
// show-ahead FIFO, plus registered output ports with one-cycle update strobes.
module io_port_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              Reset,
  io_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RELEASE} state_t;

  state_t        state_q;
  logic [1:0]    last_grant_q;
  logic [1:0]    grant_q;
  logic [1:0]    grant_d;
  logic          grant_found;
  logic [1:0]    scan_idx;
  logic [3:0]    ack_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    head;
  logic [7:0]    inp_data [4];
  logic          push;
  logic          pop;
  logic [7:0]    out_q [4];
  logic [3:0]    stb_q;

  assign inp_data[0] = bus.InpExtWorld1;
  assign inp_data[1] = bus.InpExtWorld2;
  assign inp_data[2] = bus.InpExtWorld3;
  assign inp_data[3] = bus.InpExtWorld4;

  // Scan starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_d     = last_grant_q;
    scan_idx    = last_grant_q;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_grant_q + 2'(i);
      if (!grant_found && bus.InpReq[scan_idx]) begin
        grant_found = 1'b1;
        grant_d     = scan_idx;
      end
    end
  end

  // Fullness uses the registered count, so a pop never frees space for a same-cycle grant.
  assign push = (state_q == S_IDLE) && grant_found && (count_q < CW'(FIFO_DEPTH));
  assign pop  = bus.RdEn && (count_q != '0);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'd3;
      grant_q      <= 2'd0;
      ack_q        <= 4'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      ack_q <= 4'b0;
      case (state_q)
        S_IDLE: begin
          if (push) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= S_ACK;
          end
        end
        S_ACK: begin
          ack_q   <= 4'b0001 << grant_q;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!bus.InpReq[grant_q]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the count gates everything visible at the head.
  always_ff @(posedge clk) begin
    if (Reset && push) mem_q[wr_ptr_q] <= {grant_d, inp_data[grant_d]};
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) out_q[i] <= 8'h00;
      stb_q <= 4'b0;
    end else begin
      stb_q <= 4'b0;
      if (bus.WrEn) begin
        out_q[bus.WrPort] <= bus.WrData;
        stb_q[bus.WrPort] <= 1'b1;
      end
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.RdValid   = (count_q != '0);
  assign bus.RdData    = bus.RdValid ? head[7:0] : 8'h00;
  assign bus.RdPort    = bus.RdValid ? head[9:8] : 2'd0;
  assign bus.FifoCount = count_q;
  assign bus.InpAck    = ack_q;

  assign bus.OutExtWorld1 = out_q[0];
  assign bus.OutExtWorld2 = out_q[1];
  assign bus.OutExtWorld3 = out_q[2];
  assign bus.OutExtWorld4 = out_q[3];
  assign bus.OutStb       = stb_q;
endmodule

// File: tb/tb_io_port_arbiter.sv
// Scoreboard bench for io_port_arbiter: captured bytes are queued as they are
// presented in the expected grant order and compared when popped from the FIFO.
module tb_io_port_arbiter;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  io_port_arbiter_if #(.FIFO_DEPTH(4)) bus ();
  io_port_arbiter #(.FIFO_DEPTH(4)) dut (.clk(clk), .Reset(Reset), .bus(bus));

  logic [7:0] inp [4];
  assign bus.InpExtWorld1 = inp[0];
  assign bus.InpExtWorld2 = inp[1];
  assign bus.InpExtWorld3 = inp[2];
  assign bus.InpExtWorld4 = inp[3];

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] sb [$];

  task automatic init_inputs();
    bus.InpReq = 4'b0;
    bus.RdEn   = 1'b0;
    bus.WrEn   = 1'b0;
    bus.WrPort = 2'd0;
    bus.WrData = 8'h00;
    for (int i = 0; i < 4; i++) inp[i] = 8'h00;
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    init_inputs();
    Reset = 1'b0;
    repeat (cyc) @(negedge clk);
    Reset = 1'b1;
    sb.delete();
  endtask

  task automatic wait_ack(input int p, input bit drop, input string nm);
    int t;
    t = 0;
    while (bus.InpAck === 4'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.InpAck !== 4'(1 << p)) begin
      n_bad++;
      $display("FAIL %s: InpAck got %b want %b (waited %0d cycles)", nm, bus.InpAck, 4'(1 << p), t);
    end
    if (drop) bus.InpReq[p] = 1'b0;
  endtask

  task automatic serve(input int p, input logic [7:0] d, input string nm);
    inp[p] = d;
    bus.InpReq[p] = 1'b1;
    sb.push_back({2'(p), d});
    wait_ack(p, 1'b1, nm);
    @(negedge clk);
    n_cmp++;
    if (bus.InpAck !== 4'b0) begin
      n_bad++;
      $display("FAIL %s_ack_width: InpAck got %b want 0000", nm, bus.InpAck);
    end
  endtask

  task automatic pop_check(input string nm);
    logic [9:0] e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, RdValid=%b", nm, bus.RdValid);
    end else begin
      e = sb.pop_front();
      if (bus.RdValid !== 1'b1 || bus.RdData !== e[7:0] || bus.RdPort !== e[9:8]) begin
        n_bad++;
        $display("FAIL %s: got valid=%b data=%h port=%0d want valid=1 data=%h port=%0d",
                 nm, bus.RdValid, bus.RdData, bus.RdPort, e[7:0], e[9:8]);
      end
    end
    bus.RdEn = 1'b1;
    @(negedge clk);
    bus.RdEn = 1'b0;
  endtask

  task automatic test_reset();
    init_inputs();
    Reset = 1'b0;
    bus.InpReq = 4'b1111;
    for (int i = 0; i < 4; i++) inp[i] = 8'h41 + 8'(i);
    bus.WrEn = 1'b1;
    bus.WrPort = 2'd1;
    bus.WrData = 8'h5A;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.InpAck, bus.RdValid, bus.RdData, bus.RdPort, bus.FifoCount, bus.OutExtWorld1,
           bus.OutExtWorld2, bus.OutExtWorld3, bus.OutExtWorld4, bus.OutStb} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: ack=%b valid=%b data=%h port=%0d cnt=%0d out2=%h stb=%b want all 0",
                 bus.InpAck, bus.RdValid, bus.RdData, bus.RdPort, bus.FifoCount, bus.OutExtWorld2, bus.OutStb);
      end
    end
    Reset = 1'b1;
    bus.WrEn = 1'b0;
    sb.delete();
    sb.push_back({2'd0, 8'h41});
    @(negedge clk);
    n_cmp++;
    if (bus.FifoCount !== 3'd1 || bus.RdPort !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_first_grant: cnt=%0d port=%0d want cnt=1 port=0", bus.FifoCount, bus.RdPort);
    end
    wait_ack(0, 1'b0, "reset_first_ack");
    bus.InpReq = 4'b0;
    @(negedge clk);
    pop_check("reset_first_data");
  endtask

  task automatic test_single();
    do_reset(1);
    serve(2, 8'hA5, "single");
    pop_check("single_data");
    n_cmp++;
    if (bus.RdValid !== 1'b0 || bus.FifoCount !== 3'd0) begin
      n_bad++;
      $display("FAIL single_empty: valid=%b cnt=%0d want 0/0", bus.RdValid, bus.FifoCount);
    end
  endtask

  task automatic test_round_robin();
    do_reset(1);
    for (int p = 0; p < 4; p++) begin
      inp[p] = 8'h10 + 8'(p);
      sb.push_back({2'(p), 8'h10 + 8'(p)});
    end
    bus.InpReq = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(k, 1'b1, "rr_order");
      @(negedge clk);
      n_cmp++;
      if (bus.InpAck !== 4'b0) begin
        n_bad++;
        $display("FAIL rr_ack_width: InpAck got %b want 0000", bus.InpAck);
      end
      inp[k] = 8'h20 + 8'(k);
      bus.InpReq[k] = 1'b1;
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.InpAck !== 4'b0 || bus.FifoCount !== 3'd4) begin
        n_bad++;
        $display("FAIL rr_full_hold: ack=%b cnt=%0d want 0000/4", bus.InpAck, bus.FifoCount);
      end
    end
    pop_check("rr_pop_full");
    n_cmp++;
    if (bus.FifoCount !== 3'd3 || bus.InpAck !== 4'b0) begin
      n_bad++;
      $display("FAIL full_pop_no_grant: cnt=%0d ack=%b want 3/0000", bus.FifoCount, bus.InpAck);
    end
    sb.push_back({2'd0, 8'h20});
    @(negedge clk);
    n_cmp++;
    if (bus.FifoCount !== 3'd4) begin
      n_bad++;
      $display("FAIL full_regrant: cnt=%0d want 4", bus.FifoCount);
    end
    wait_ack(0, 1'b1, "rr_after_pop");
    bus.InpReq = 4'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) pop_check("rr_drain");
  endtask

  task automatic test_empty_pop();
    do_reset(1);
    bus.RdEn = 1'b1;
    @(negedge clk);
    bus.RdEn = 1'b0;
    n_cmp++;
    if (bus.FifoCount !== 3'd0 || bus.RdValid !== 1'b0 || bus.RdData !== 8'h00 || bus.RdPort !== 2'd0) begin
      n_bad++;
      $display("FAIL empty_pop: cnt=%0d valid=%b data=%h port=%0d want 0", bus.FifoCount, bus.RdValid,
               bus.RdData, bus.RdPort);
    end
    serve(1, 8'h77, "after_empty_pop");
    pop_check("after_empty_pop_data");
  endtask

  task automatic test_wrap();
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      serve(i % 4, 8'h30 + 8'(i * 7), "wrap");
      if (i >= 2) pop_check("wrap_data");
    end
    while (sb.size() > 0) pop_check("wrap_drain");
    n_cmp++;
    if (bus.RdValid !== 1'b0 || bus.FifoCount !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_empty: valid=%b cnt=%0d want 0/0", bus.RdValid, bus.FifoCount);
    end
  endtask

  task automatic test_outputs();
    do_reset(1);
    bus.WrEn = 1'b1;
    bus.WrPort = 2'd1;
    bus.WrData = 8'h11;
    @(negedge clk);
    n_cmp++;
    if (bus.OutExtWorld2 !== 8'h11 || bus.OutStb !== 4'b0010) begin
      n_bad++;
      $display("FAIL out_port2: out2=%h stb=%b want 11/0010", bus.OutExtWorld2, bus.OutStb);
    end
    bus.WrPort = 2'd3;
    bus.WrData = 8'h22;
    @(negedge clk);
    bus.WrEn = 1'b0;
    n_cmp++;
    if (bus.OutExtWorld4 !== 8'h22 || bus.OutStb !== 4'b1000 || bus.OutExtWorld2 !== 8'h11 ||
        bus.OutExtWorld1 !== 8'h00 || bus.OutExtWorld3 !== 8'h00) begin
      n_bad++;
      $display("FAIL out_port4: out4=%h stb=%b out2=%h want 22/1000/11", bus.OutExtWorld4, bus.OutStb,
               bus.OutExtWorld2);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.OutStb !== 4'b0 || bus.OutExtWorld4 !== 8'h22) begin
      n_bad++;
      $display("FAIL out_stb_clear: stb=%b out4=%h want 0000/22", bus.OutStb, bus.OutExtWorld4);
    end
  endtask

  task automatic test_reset_release();
    do_reset(1);
    bus.WrEn = 1'b1;
    bus.WrPort = 2'd0;
    bus.WrData = 8'h99;
    inp[0] = 8'hC3;
    bus.InpReq[0] = 1'b1;
    @(negedge clk);
    bus.WrEn = 1'b0;
    wait_ack(0, 1'b0, "rel_ack");
    @(negedge clk);
    n_cmp++;
    if (bus.FifoCount !== 3'd1 || bus.OutExtWorld1 !== 8'h99) begin
      n_bad++;
      $display("FAIL rel_pre: cnt=%0d out1=%h want 1/99", bus.FifoCount, bus.OutExtWorld1);
    end
    Reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.InpAck, bus.RdValid, bus.RdData, bus.RdPort, bus.FifoCount, bus.OutExtWorld1, bus.OutStb} !== '0) begin
      n_bad++;
      $display("FAIL rel_reset: ack=%b valid=%b cnt=%0d out1=%h want all 0", bus.InpAck, bus.RdValid,
               bus.FifoCount, bus.OutExtWorld1);
    end
    Reset = 1'b1;
    bus.InpReq = 4'b0;
    sb.delete();
    @(negedge clk);
    n_cmp++;
    if (bus.FifoCount !== 3'd0 || bus.InpAck !== 4'b0) begin
      n_bad++;
      $display("FAIL rel_idle: cnt=%0d ack=%b want 0/0000", bus.FifoCount, bus.InpAck);
    end
    serve(3, 8'h3C, "rel_after");
    pop_check("rel_after_data");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_empty_pop();
    test_wrap();
    test_outputs();
    test_reset_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
